// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and state encoding for the UART frame deframer
package uart_frame_pkg;

    localparam int LEN_W = 8;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LEN     = 3'd1;
    localparam state_t ST_PAYLOAD = 3'd2;
    localparam state_t ST_CSUM    = 3'd3;
    localparam state_t ST_DRAIN   = 3'd4;

endpackage

// File: rtl/uart_frame_rx_frame_buf.sv
// rtl/uart_frame_rx_frame_buf.sv - payload buffer, one write port and one registered read port
module frame_buf #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass: a one-byte frame is read in the same cycle its byte is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - sync hunt, length-prefixed capture and packet release; UART_FRAME_CHECK_EN adds a trailing XOR checksum
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         MAX_LEN    = 64,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  frame_ok,
    output logic                  frame_err
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] wr_idx;
    logic [LEN_W-1:0] rd_idx;
    logic             accept;
    logic             xfer;
    logic             we;
    logic             wr_last;
    logic             rd_en;
    logic             drain_start;
    logic             len_bad;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    assign s_ready = (state != ST_DRAIN);
    assign accept  = s_valid && s_ready;
    assign xfer    = m_valid && m_ready;
    assign len_bad = (s_data == '0) || (s_data > MAX_LEN_B);
    assign wr_last = (wr_idx == len - LEN_W'(1));
    assign we      = accept && (state == ST_PAYLOAD);
    assign wr_addr = AW'(wr_idx);

`ifdef UART_FRAME_CHECK_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (accept && (state == ST_LEN)) begin
            csum <= s_data;
        end else if (we) begin
            csum <= csum ^ s_data;
        end
    end

    always_comb begin
        drain_start = 1'b0;
        drain_start = accept && (state == ST_CSUM) && (s_data == csum);
    end
`else
    always_comb begin
        drain_start = 1'b0;
        drain_start = we && wr_last;
    end
`endif

    // Byte 0 is fetched as the frame is accepted so it lands together with frame_ok.
    assign rd_en   = drain_start || ((state == ST_DRAIN) && xfer && !m_last);
    assign rd_addr = drain_start ? '0 : AW'(rd_idx + LEN_W'(1));

    frame_buf #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && (s_data == SYNC_BYTE)) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            len    <= s_data;
                            wr_idx <= '0;
                            state  <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        if (!wr_last) begin
                            wr_idx <= wr_idx + LEN_W'(1);
                        end
`ifdef UART_FRAME_CHECK_EN
                        else begin
                            state <= ST_CSUM;
                        end
`endif
                    end
                end
`ifdef UART_FRAME_CHECK_EN
                ST_CSUM: begin
                    if (accept && !drain_start) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`endif
                ST_DRAIN: begin
                    if (xfer) begin
                        if (m_last) begin
                            state   <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end else begin
                            rd_idx <= rd_idx + LEN_W'(1);
                            m_last <= ((rd_idx + LEN_W'(1)) == (len - LEN_W'(1)));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (drain_start) begin
                state    <= ST_DRAIN;
                frame_ok <= 1'b1;
                m_valid  <= 1'b1;
                m_last   <= (len == LEN_W'(1));
                rd_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx (checksum frames when UART_FRAME_CHECK_EN is defined)
module tb_uart_frame_rx;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int mv_cnt = 0;
    int srdy_low = 0;
    int ok_cyc = 0;
    int last_cyc = 0;
    int bp_mode = 0;
    bit mon_off = 1'b0;
    bit prev_last_xfer = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] pbuf[256];

    uart_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, other = held low.
    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !mon_off) begin
            if (frame_ok) begin
                ok_cnt++;
                ok_cyc = cyc;
                chk("mvalid_with_ok", m_valid, 1);
            end
            if (frame_err) err_cnt++;
            if (!s_ready) srdy_low++;
            if (prev_last_xfer) chk("sready_after_last", s_ready, 1);
            prev_last_xfer = 1'b0;
            if (m_valid) begin
                mv_cnt++;
                chk("sready_low_in_drain", s_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", m_valid, 0);
                end else begin
                    chk("m_data", m_data, exp_q[0][7:0]);
                    chk("m_last", m_last, exp_q[0][8]);
                    if (m_ready) begin
                        exp_q.delete(0);
                        if (m_last) begin
                            last_cyc = cyc;
                            prev_last_xfer = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", n, 0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input bit corrupt, output bit good);
        logic [7:0] cs;
        logic [8:0] e;
        bit legal;
        legal = (len != 8'd0) && (len <= 8'd64);
        cs = len;
        for (int i = 0; i < int'(len); i++) cs = cs ^ pbuf[i];
`ifdef UART_FRAME_CHECK_EN
        if (corrupt) cs = cs ^ 8'h07;
        good = legal && !corrupt;
`else
        good = legal;
`endif
        if (good) begin
            for (int i = 0; i < int'(len); i++) begin
                e = {1'b0, pbuf[i]};
                e[8] = (i == int'(len) - 1);
                exp_q.push_back(e);
            end
        end
        send_byte(8'hA5);
        send_byte(len);
        if (legal) begin
            for (int i = 0; i < int'(len); i++) send_byte(pbuf[i]);
`ifdef UART_FRAME_CHECK_EN
            send_byte(cs);
`endif
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] len, input bit corrupt, input bit check_lat);
        int ok0;
        int err0;
        bit good;
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_frame(len, corrupt, good);
        wait_drain();
        chk("ok_pulses", ok_cnt - ok0, good);
        chk("err_pulses", err_cnt - err0, !good);
        if (check_lat && good) chk("drain_latency", last_cyc - ok_cyc, int'(len) - 1);
    endtask

    task automatic load3();
        pbuf[0] = 8'h11;
        pbuf[1] = 8'h22;
        pbuf[2] = 8'h33;
    endtask

    initial begin
        int mv0;
        int s0;
        int ok0;
        int err0;
        logic [7:0] rlen;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);

        load3();
        run_frame(8'd3, 1'b0, 1'b1);

`ifdef UART_FRAME_CHECK_EN
        mv0 = mv_cnt;
        s0  = srdy_low;
        run_frame(8'd3, 1'b1, 1'b0);
        chk("bad_csum_no_mvalid", mv_cnt - mv0, 0);
        chk("bad_csum_sready_high", srdy_low - s0, 0);
`endif

        run_frame(8'd0, 1'b0, 1'b0);
        run_frame(8'h41, 1'b0, 1'b0);
        pbuf[0] = 8'hAA;
        pbuf[1] = 8'hBB;
        run_frame(8'd2, 1'b0, 1'b1);

        pbuf[0] = 8'hA5;
        run_frame(8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) pbuf[i] = 8'($urandom);
        run_frame(8'd64, 1'b0, 1'b1);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        load3();
        run_frame(8'd3, 1'b0, 1'b1);

        bp_mode = 1;
        run_frame(8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) pbuf[i] = 8'($urandom);
        run_frame(8'd10, 1'b0, 1'b0);
        bp_mode = 0;
        repeat (2) @(negedge clk);

        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        rst = 1'b1;
        #1;
        chk("midpay_m_valid", m_valid, 0);
        chk("midpay_s_ready", s_ready, 1);
        chk("midpay_frame_ok", frame_ok, 0);
        chk("midpay_frame_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midpay_no_ok", ok_cnt - ok0, 0);
        chk("midpay_no_err", err_cnt - err0, 0);
        load3();
        run_frame(8'd3, 1'b0, 1'b1);

        mon_off = 1'b1;
        bp_mode = 2;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
`ifdef UART_FRAME_CHECK_EN
        send_byte(8'h13);
`endif
        repeat (2) @(negedge clk);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_s_ready", s_ready, 0);
        chk("stall_m_data", m_data, 8'hAA);
        rst = 1'b1;
        #1;
        chk("middrain_m_valid", m_valid, 0);
        chk("middrain_s_ready", s_ready, 1);
        chk("middrain_m_data", m_data, 0);
        chk("middrain_m_last", m_last, 0);
        @(negedge clk);
        rst = 1'b0;
        bp_mode = 0;
        @(negedge clk);
        @(negedge clk);
        mon_off = 1'b0;
        load3();
        run_frame(8'd3, 1'b0, 1'b1);

        for (int f = 0; f < 6; f++) begin
            rlen = 8'($urandom_range(1, 64));
            for (int i = 0; i < int'(rlen); i++) pbuf[i] = 8'($urandom);
            bp_mode = int'($urandom_range(0, 1));
            run_frame(rlen, ($urandom_range(0, 3) == 0), (bp_mode == 0));
        end
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-stream deframer that sits on the receive-side AXI-Stream output of the UART block. It hunts for a sync byte, captures a length-prefixed payload into an internal buffer and verifies the trailing checksum. It releases the payload downstream as a packet only when the frame is good, so the NoC command path never sees partial or corrupt frames.

## Interface
- DATA_WIDTH, 8: byte width; fixed at 8, other values unsupported.
- MAX_LEN, 64: maximum payload bytes per frame, 1..255; sets buffer depth.
- SYNC_BYTE, 8'hA5: frame start marker.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- s_data  in  8  byte from the UART receive stream.
- s_valid  in  1  byte valid.
- s_ready  out  1  deframer can accept a byte.
- m_data  out  8  payload byte out.
- m_valid  out  1  payload byte valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  marks the final payload byte of a frame.
- frame_ok  out  1  one-cycle pulse: frame accepted.
- frame_err  out  1  one-cycle pulse: frame discarded.

## Operation
- Frame on the wire: SYNC, LEN, LEN payload bytes, then CSUM (CSUM present only with checking enabled).
- CSUM is the XOR of LEN and all payload bytes.
- Byte transfer on the input occurs when s_valid && s_ready. Output transfer occurs when m_valid && m_ready.
- State machine:
  - IDLE: a byte equal to SYNC_BYTE goes to LEN. Any other byte is dropped silently.
  - LEN: LEN==0 or LEN>MAX_LEN pulses frame_err and returns to IDLE. Otherwise store LEN, clear the write index, seed the running XOR with LEN, and go to PAYLOAD.
  - PAYLOAD: write the byte to buffer[idx] and fold it into the XOR. After LEN bytes, go to CSUM (or DRAIN when checking is compiled out).
  - CSUM: on match, pulse frame_ok and go to DRAIN. On mismatch, pulse frame_err and go to IDLE.
  - DRAIN: present buffer[0..LEN-1] in order. m_last is high with byte LEN-1. After that byte transfers, go to IDLE.
- s_ready is 1 in IDLE, LEN, PAYLOAD and CSUM, and 0 in DRAIN. Input is backpressured only while draining.
- A SYNC_BYTE value appearing inside the payload or CSUM is treated as data; there is no resync mid-frame.
- Index and length counters are 8 bits. The write index never exceeds LEN-1 and the read index never wraps.

## Timing
- Reset values: s_ready=1, m_valid=0, m_last=0, m_data=0, frame_ok=0, frame_err=0, state=IDLE, all counters 0.
- Outputs m_valid, m_data, m_last, frame_ok and frame_err are registered. s_ready is decoded from the state register.
- frame_ok/frame_err are asserted in the cycle after the deciding byte is accepted, and last exactly one cycle.
- The first m_valid appears in the same cycle as frame_ok, i.e. one cycle after CSUM is accepted.
- With m_ready held high, DRAIN delivers one byte per cycle. Latency from frame_ok to m_last is LEN-1 cycles.
- Holds while m_valid && !m_ready: m_data, m_last and m_valid stay stable until the transfer.
- s_ready rises in the cycle after the m_last transfer.
- Reset asserted mid-frame or mid-drain: the frame is lost with no pulse, and outputs take their reset values immediately (asynchronously).

## Configuration
- UART_FRAME_CHECK_EN defined: a CSUM byte is expected and verified. Bad frames are discarded with frame_err.
- Not defined: there is no CSUM byte and no CSUM state. After the last payload byte, frame_ok pulses and DRAIN starts. frame_err fires only for an illegal LEN.

## Structure
- Package uart_frame_pkg holds:
  - the state enum (IDLE, LEN, PAYLOAD, CSUM, DRAIN);
  - the default SYNC_BYTE constant;
  - the LEN_W=8 width constant.
- Sub-module frame_buf: MAX_LEN x 8 simple dual-port buffer with one write port and one registered read port. No reset on the contents.

## Test plan
- Good frame: input A5 03 11 22 33 03, m_ready=1 -> outputs 11, 22, 33 on consecutive cycles, m_last on 33, one frame_ok, no frame_err.
- Bad checksum: input A5 03 11 22 33 04 -> one frame_err, m_valid never asserted, s_ready stays 1.
- Illegal length: input A5 00, and separately A5 41 with MAX_LEN=64 -> frame_err after the LEN byte. A following A5 02 AA BB 13 is accepted normally.
- Hunting: input 00 FF 5A followed by the good frame above -> the garbage is dropped and the output is identical to the good-frame case.
- Backpressure: good frame with m_ready toggling 1,0,0,1,... -> no byte lost or duplicated, and m_data is stable while stalled. s_ready stays 0 during drain and returns 1 the cycle after the m_last transfer.
- Reset mid-payload: assert rst after A5 03 11 -> outputs reset immediately. After release, a good frame is delivered intact.
